// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner of a 4:1 stream mux: grants one requester for up to BURST beats,
// then rotates; the data path is combinational through the granted input.
module mux4_rr_scheduler #(
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    in_valid,
  input  logic [DW-1:0] in_data_a,
  input  logic [DW-1:0] in_data_b,
  input  logic [DW-1:0] in_data_c,
  input  logic [DW-1:0] in_data_d,
  output logic [3:0]    in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [1:0]    sel,
  output logic [3:0]    grant,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [7:0] LAST_BEAT = 8'(BURST - 1);

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [1:0]    ptr_q;
  logic [3:0]    grant_q;
  logic          busy_q;
  logic [7:0]    cnt_q;

  logic          granted;
  logic          sel_valid;
  logic          xfer;
  logic          release_now;
  logic [1:0]    ptr_rel;
  logic [1:0]    search_base;
  logic [2:0]    win;
  logic [DW-1:0] mux_data;

  // Returns {found, index} of the first requester at or after base, wrapping mod 4.
  function automatic logic [2:0] pick(input logic [1:0] base, input logic [3:0] req);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign granted     = (state_q == GRANT);
  assign sel_valid   = in_valid[sel_q];
  assign out_valid   = granted & sel_valid;
  assign xfer        = out_valid & out_ready;
  assign release_now = granted & (~sel_valid | (xfer & (cnt_q == LAST_BEAT)));
  assign ptr_rel     = sel_q + 2'd1;
  // On a release the search already starts past the outgoing owner.
  assign search_base = granted ? ptr_rel : ptr_q;
  assign win         = pick(search_base, in_valid);

  always_comb begin
    mux_data = in_data_a;
    case (sel_q)
      2'd0: mux_data = in_data_a;
      2'd1: mux_data = in_data_b;
      2'd2: mux_data = in_data_c;
      2'd3: mux_data = in_data_d;
      default: mux_data = in_data_a;
    endcase
  end

  assign out_data = granted ? mux_data : '0;

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign in_ready[gi] = granted & (sel_q == 2'(gi)) & out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      ptr_q   <= 2'd0;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win[2]) begin
            state_q <= GRANT;
            sel_q   <= win[1:0];
            grant_q <= 4'b0001 << win[1:0];
            busy_q  <= 1'b1;
            cnt_q   <= 8'd0;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_q <= ptr_rel;
            cnt_q <= 8'd0;
            if (win[2]) begin
              sel_q   <= win[1:0];
              grant_q <= 4'b0001 << win[1:0];
            end else begin
              state_q <= IDLE;
              grant_q <= 4'b0000;
              busy_q  <= 1'b0;
            end
          end else if (xfer) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  assign sel   = sel_q;
  assign grant = grant_q;
  assign busy  = busy_q;

endmodule
